multi_wave_generator: RTL and testbench
=======================================

# multi_wave_generator

Parametrised, multi-channel successor to the single-tone square-wave generator in the melody datapath. It runs CHANNELS independent tone channels. Each channel has a programmable full-cycle period and a selectable duty cycle. New periods and duties take effect only at a cycle boundary, so pitch changes never glitch. The block outputs the per-channel waves and a registered count of channels currently high, which the audio DAC/PWM stage uses to mix voices.

## Interface
- CHANNELS, 4 — number of tone channels (1..16)
- WIDTH, 32 — period / counter width in bits
- MIXW, $clog2(CHANNELS+1) — width of the mix output (derived localparam)

- clk  in  1  system clock. Single clock domain; reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset
- en  in  CHANNELS  per-channel enable; level-sensitive
- period  in  CHANNELS*WIDTH  full-cycle length in clk cycles; channel i is period[i*WIDTH +: WIDTH]
- duty  in  CHANNELS*2  per-channel duty select; channel i is duty[2*i +: 2]
- wave  out  CHANNELS  per-channel square wave, registered
- tick  out  CHANNELS  one-cycle pulse when a channel begins a new wave cycle, registered
- mix  out  MIXW  number of bits set in wave, delayed one cycle

## Operation
- Per-channel state:
  - IDLE/RUN flag
  - counter cnt[WIDTH-1:0]
  - active period P_a and active duty D_a (shadow registers)
- High time H from (P_a, D_a):
  - 00 → P_a>>1 (50 %)
  - 01 → P_a>>2 (25 %)
  - 10 → P_a>>3 (12.5 %)
  - 11 → P_a − (P_a>>2) (75 %)
  - Arithmetic is unsigned WIDTH bits; no overflow is possible.
- IDLE → RUN when en[i]=1 is sampled:
  - P_a←period, D_a←duty, cnt←0, tick←1
  - wave←(H>0), with H computed from the newly sampled values
- RUN, cnt < P_a−1: cnt←cnt+1, wave←(cnt+1 < H), tick←0.
- RUN, cnt = P_a−1 (wrap):
  - cnt←0, tick←1
  - P_a←period and D_a←duty (reload occurs only here)
  - wave←(H_new>0)
- RUN with en[i]=0 sampled: go to IDLE next edge; cnt←0, wave←0, tick←0. Takes priority over a simultaneous wrap.
- Degenerate period: P_a < 2 yields silence.
  - The channel stays in RUN with wave held 0; tick pulses every cycle for P_a=1 and every cycle for P_a=0, which is treated as 1.
  - A legal period loaded at the next wrap restores output.
- Invariant while running: wave == (cnt < H), so a full cycle is exactly P_a clocks with H clocks high.
- Channels are fully independent; simultaneous wraps need no arbitration.
- mix ← popcount(wave), registered.

## Timing
- Reset values: wave=0, tick=0, mix=0, cnt=0, P_a=0, D_a=0; all channels IDLE.
- Reset is asynchronous and may assert mid-cycle; outputs clear immediately. After release, a channel with en=1 starts on the first clock edge.
- Enable latency: en sampled high at edge k → wave/tick valid after edge k, and the first cycle is counted from edge k.
- Period/duty changes mid-cycle are ignored until the wrap edge. Latency is at most P_a clocks, with no truncated or stretched cycle.
- mix lags wave by exactly one clock.
- No combinational path from inputs to outputs.

## Structure
- Package wave_pkg holds:
  - duty codes DUTY_50/25/12/75 (2-bit localparams)
  - function high_time(period, duty) shared by RTL and bench
- Sub-module wave_channel: one channel (state, cnt, shadows, wave, tick). Parameter WIDTH; ports clk, rst, en, period, duty, wave, tick.
- Top level multi_wave_generator:
  - generate loop of CHANNELS wave_channel instances
  - registered popcount for mix

## Test plan
- Ch0 en=1, P=8, duty=00 → wave 1111_0000 repeating; tick at cnt=0 every 8 clocks; other channels stay 0.
- Ch0 P=8, duty=01 then duty=11 (changed at cnt=3) → current cycle stays 11000000; the next cycle after the wrap is 11111100.
- Ch1 P=10 running; change period to 6 at cnt=2 → the 10-clock cycle completes (5 high, 5 low), then 6-clock cycles (3 high, 3 low); no glitch at the boundary.
- en dropped at cnt=2 with P=8 → wave=0 and tick=0 next edge. Re-enable → cycle restarts at cnt=0 with tick=1.
- P=1 and P=0 → wave constantly 0. Load P=4 → first wrap yields 1100 pattern.
- All 4 channels P=4, duty=00, enabled together → mix reads 4,4,0,0 repeating one clock behind wave. Assert rst mid-cycle → all outputs 0 immediately; after release, restart from cnt=0.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared definitions for the multi-channel tone generator:
// duty codes, channel state encoding and the high-time helper.
package wave_pkg;

   localparam logic [1:0] DUTY_50 = 2'b00;
   localparam logic [1:0] DUTY_25 = 2'b01;
   localparam logic [1:0] DUTY_12 = 2'b10;
   localparam logic [1:0] DUTY_75 = 2'b11;

   // Widest period the helper handles; callers narrow the result.
   localparam int MAX_W = 64;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ch_state_e;

   // Clocks high per cycle for a given period and duty code.
   function automatic logic [MAX_W-1:0] high_time(
      input logic [MAX_W-1:0] p,
      input logic [1:0]       d
   );
      logic [MAX_W-1:0] h;
      case (d)
         DUTY_50: h = p >> 1;
         DUTY_25: h = p >> 2;
         DUTY_12: h = p >> 3;
         DUTY_75: h = p - (p >> 2);
         default: h = '0;
      endcase
      return h;
   endfunction

endpackage

// File: rtl/wave_channel.sv
// One tone channel: cycle counter, shadowed period/duty, wave and tick.
// Ports: clk, rst, en, period, duty in; wave, tick out (registered).
module wave_channel
   import wave_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] period,
   input  logic [1:0]       duty,
   output logic             wave,
   output logic             tick
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

   ch_state_e        state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] pa_q, pa_d;
   logic [1:0]       da_q, da_d;
   logic             wave_q, wave_d;
   logic             tick_q, tick_d;

   logic [WIDTH-1:0] h_new;
   logic [WIDTH-1:0] h_act;
   logic [WIDTH-1:0] cnt_inc;
   logic             new_ok;
   logic             last;

   assign h_new   = WIDTH'(high_time(MAX_W'(period), duty));
   assign h_act   = WIDTH'(high_time(MAX_W'(pa_q), da_q));
   assign cnt_inc = cnt_q + ONE;

   // Periods below 2 are silent even when the duty math says otherwise.
   assign new_ok = (period >= TWO) && (h_new != '0);

   // P_a of 0 behaves as 1: every cycle is a wrap.
   assign last = (pa_q < TWO) || (cnt_q == pa_q - ONE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pa_d    = pa_q;
      da_d    = da_q;
      wave_d  = 1'b0;
      tick_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (en) begin
               state_d = ST_RUN;
               pa_d    = period;
               da_d    = duty;
               tick_d  = 1'b1;
               wave_d  = new_ok;
            end
         end
         ST_RUN: begin
            if (!en) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (last) begin
               cnt_d  = '0;
               pa_d   = period;
               da_d   = duty;
               tick_d = 1'b1;
               wave_d = new_ok;
            end else begin
               cnt_d  = cnt_inc;
               wave_d = (cnt_inc < h_act);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pa_q    <= '0;
         da_q    <= 2'b00;
         wave_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pa_q    <= pa_d;
         da_q    <= da_d;
         wave_q  <= wave_d;
         tick_q  <= tick_d;
      end
   end

   assign wave = wave_q;
   assign tick = tick_q;

endmodule

// File: rtl/multi_wave_generator.sv
// CHANNELS independent square-wave tone channels plus a registered
// count of high channels. Ports: clk, rst, en, period, duty in;
// wave, tick, mix out.
module multi_wave_generator
   import wave_pkg::*;
#(
   parameter  int CHANNELS = 4,
   parameter  int WIDTH    = 32,
   localparam int MIXW     = $clog2(CHANNELS + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS*WIDTH-1:0] period,
   input  logic [CHANNELS*2-1:0]     duty,
   output logic [CHANNELS-1:0]       wave,
   output logic [CHANNELS-1:0]       tick,
   output logic [MIXW-1:0]           mix
);

   logic [MIXW-1:0] ones;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      wave_channel #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .en     (en[i]),
         .period (period[i*WIDTH +: WIDTH]),
         .duty   (duty[2*i +: 2]),
         .wave   (wave[i]),
         .tick   (tick[i])
      );
   end

   always_comb begin
      ones = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         ones = ones + MIXW'(wave[i]);
      end
   end

   // Counts the registered waves, so mix trails wave by one clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mix <= '0;
      end else begin
         mix <= ones;
      end
   end

endmodule

// File: tb/tb_multi_wave_generator.sv
// Directed bench for multi_wave_generator: per-cycle expectations are
// queued as stimulus is driven and compared once the clock edge lands.
module tb_multi_wave_generator;
   import wave_pkg::*;

   localparam int CH = 4;
   localparam int W  = 32;
   localparam int MW = $clog2(CH + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic [CH-1:0]   en;
   logic [CH*W-1:0] period;
   logic [CH*2-1:0] duty;
   logic [CH-1:0]   wave;
   logic [CH-1:0]   tick;
   logic [MW-1:0]   mix;

   typedef struct packed {
      logic [CH-1:0] w;
      logic [CH-1:0] t;
      logic [MW-1:0] m;
   } exp_t;

   exp_t          sb[$];
   logic [CH-1:0] prev_w;
   int            checks = 0;
   int            errors = 0;

   multi_wave_generator #(
      .CHANNELS (CH),
      .WIDTH    (W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .period (period),
      .duty   (duty),
      .wave   (wave),
      .tick   (tick),
      .mix    (mix)
   );

   always #5 clk = ~clk;

   function automatic logic [MW-1:0] ones(input logic [CH-1:0] v);
      logic [MW-1:0] n;
      n = '0;
      for (int i = 0; i < CH; i++) n = n + MW'(v[i]);
      return n;
   endfunction

   // Queue the expected outputs for the next edge, then check them.
   task automatic cyc(input logic [CH-1:0] w, input logic [CH-1:0] t,
                      input string tag);
      exp_t e;
      e.w = w;
      e.t = t;
      e.m = ones(prev_w);
      prev_w = w;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      assert (wave === e.w) else begin
         errors++;
         $error("FAIL %s wave got=%b exp=%b", tag, wave, e.w);
      end
      checks++;
      assert (tick === e.t) else begin
         errors++;
         $error("FAIL %s tick got=%b exp=%b", tag, tick, e.t);
      end
      checks++;
      assert (mix === e.m) else begin
         errors++;
         $error("FAIL %s mix got=%0d exp=%0d", tag, mix, e.m);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CH-1:0] w, t;
      rst    = 1'b1;
      en     = '0;
      period = '0;
      duty   = '0;
      prev_w = '0;

      cyc('0, '0, "reset");
      cyc('0, '0, "reset");
      rst = 1'b0;
      cyc('0, '0, "idle");

      // ch0, P=8, 50 %
      period[0 +: W] = 8;
      duty[1:0]      = DUTY_50;
      en[0]          = 1'b1;
      for (int j = 0; j < 16; j++) begin
         w = '0; t = '0;
         w[0] = (j % 8) < 4;
         t[0] = (j % 8) == 0;
         cyc(w, t, "ch0_50");
      end

      // 25 % cycle, switch to 75 % mid-cycle at cnt=3
      duty[1:0] = DUTY_25;
      for (int j = 0; j < 8; j++) begin
         w = '0; t = '0;
         w[0] = j < 2;
         t[0] = j == 0;
         cyc(w, t, "ch0_25");
         if (j == 3) duty[1:0] = DUTY_75;
      end
      for (int j = 0; j < 8; j++) begin
         w = '0; t = '0;
         w[0] = j < 6;
         t[0] = j == 0;
         cyc(w, t, "ch0_75");
      end

      // Drop enable at cnt=2, then restart
      for (int j = 0; j < 3; j++) begin
         w = '0; t = '0;
         w[0] = 1'b1;
         t[0] = j == 0;
         cyc(w, t, "ch0_pre_drop");
      end
      en[0] = 1'b0;
      cyc('0, '0, "ch0_drop");
      cyc('0, '0, "ch0_off");
      duty[1:0] = DUTY_50;
      en[0]     = 1'b1;
      for (int j = 0; j < 8; j++) begin
         w = '0; t = '0;
         w[0] = j < 4;
         t[0] = j == 0;
         cyc(w, t, "ch0_restart");
      end
      en[0] = 1'b0;
      cyc('0, '0, "ch0_stop");

      // ch1, P=10 then period 6 requested at cnt=2
      period[W +: W] = 10;
      duty[3:2]      = DUTY_50;
      en[1]          = 1'b1;
      for (int j = 0; j < 10; j++) begin
         w = '0; t = '0;
         w[1] = j < 5;
         t[1] = j == 0;
         cyc(w, t, "ch1_p10");
         if (j == 2) period[W +: W] = 6;
      end
      for (int j = 0; j < 12; j++) begin
         w = '0; t = '0;
         w[1] = (j % 6) < 3;
         t[1] = (j % 6) == 0;
         cyc(w, t, "ch1_p6");
      end
      en[1] = 1'b0;
      cyc('0, '0, "ch1_stop");

      // ch2 degenerate periods, then recovery
      period[2*W +: W] = 1;
      duty[5:4]        = DUTY_75;
      en[2]            = 1'b1;
      for (int j = 0; j < 4; j++) begin
         t = '0;
         t[2] = 1'b1;
         cyc('0, t, "ch2_p1");
      end
      period[2*W +: W] = 0;
      for (int j = 0; j < 4; j++) begin
         t = '0;
         t[2] = 1'b1;
         cyc('0, t, "ch2_p0");
      end
      period[2*W +: W] = 4;
      duty[5:4]        = DUTY_50;
      for (int j = 0; j < 8; j++) begin
         w = '0; t = '0;
         w[2] = (j % 4) < 2;
         t[2] = (j % 4) == 0;
         cyc(w, t, "ch2_p4");
      end
      en[2] = 1'b0;
      cyc('0, '0, "ch2_stop");

      // All channels P=4 together; mix trails wave
      for (int i = 0; i < CH; i++) begin
         period[i*W +: W] = 4;
         duty[2*i +: 2]   = DUTY_50;
      end
      en = '1;
      for (int j = 0; j < 10; j++) begin
         w = ((j % 4) < 2) ? '1 : '0;
         t = ((j % 4) == 0) ? '1 : '0;
         cyc(w, t, "all");
      end

      // Asynchronous reset mid-cycle
      #3;
      rst = 1'b1;
      #1;
      checks++;
      assert (wave === '0) else begin
         errors++;
         $error("FAIL async_rst wave got=%b exp=%b", wave, 4'b0000);
      end
      checks++;
      assert (tick === '0) else begin
         errors++;
         $error("FAIL async_rst tick got=%b exp=%b", tick, 4'b0000);
      end
      checks++;
      assert (mix === '0) else begin
         errors++;
         $error("FAIL async_rst mix got=%0d exp=0", mix);
      end
      prev_w = '0;
      cyc('0, '0, "in_reset");
      rst = 1'b0;
      for (int j = 0; j < 8; j++) begin
         w = ((j % 4) < 2) ? '1 : '0;
         t = ((j % 4) == 0) ? '1 : '0;
         cyc(w, t, "after_rst");
      end
      en = '0;
      cyc('0, '0, "all_stop");
      cyc('0, '0, "all_quiet");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
